// File: rtl/regfile_2r1w.sv
// Purpose: parametrised 2-read / 1-write register file with write bypass, optional zero register and range checks.
// Latency: reads take 1 cycle when REG_READ=1 and 0 cycles when REG_READ=0; writes are visible on the next cycle, or the same cycle with BYPASS.
// Backpressure: none; it accepts one read pair and one write every cycle.
// Ports: clk/rst (sync, active-high); we/waddr/wdata write port; rd_en/ra_sel/rb_sel read request;
//        rda/rdb/rd_valid read result; addr_err pulses the cycle after an out-of-range access.
module regfile_2r1w #(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 8,
  parameter int REG_READ = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic [AW-1:0]    ra_sel,
  input  logic [AW-1:0]    rb_sel,
  output logic [WIDTH-1:0] rda,
  output logic [WIDTH-1:0] rdb,
  output logic             rd_valid,
  output logic             addr_err
);

  // The depth is widened by one bit so that the comparison also works when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam bit          POW2    = (DEPTH == (1 << AW));

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_addr_err;

  logic             w_wr_inr;
  logic             w_ra_oor;
  logic             w_rb_oor;
  logic             w_wr_en;
  logic             w_err;
  logic [WIDTH-1:0] w_rda_val;
  logic [WIDTH-1:0] w_rdb_val;

  // The priority order is: out of range, then zero register, then bypass, then storage.
  function automatic logic [WIDTH-1:0] f_read(
    input logic [AW-1:0]    s,
    input logic             oor,
    input logic [WIDTH-1:0] word,
    input logic             f_we,
    input logic [AW-1:0]    f_waddr,
    input logic [WIDTH-1:0] f_wdata
  );
    if (oor)                                  return '0;
    if (ZERO_REG != 0 && s == '0)             return '0;
    if (BYPASS != 0 && f_we && f_waddr == s)  return f_wdata;
    return word;
  endfunction

  assign w_wr_inr = {1'b0, waddr}  < DEPTH_W;
  assign w_ra_oor = {1'b0, ra_sel} >= DEPTH_W;
  assign w_rb_oor = {1'b0, rb_sel} >= DEPTH_W;

  // A write to register 0 in zero-register mode is dropped without raising an error.
  assign w_wr_en  = we && w_wr_inr && !(ZERO_REG != 0 && waddr == '0);

  // When DEPTH is a power of two, every address is in range, so the flag reduces to a constant 0.
  assign w_err    = !POW2 && ((we && !w_wr_inr) || (rd_en && (w_ra_oor || w_rb_oor)));

  // Out-of-range selects may index past DEPTH here; f_read discards that word.
  assign w_rda_val = f_read(ra_sel, w_ra_oor, r_mem[ra_sel], we, waddr, wdata);
  assign w_rdb_val = f_read(rb_sel, w_rb_oor, r_mem[rb_sel], we, waddr, wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_wr_en) r_mem[waddr] <= wdata;
      r_addr_err <= w_err;
    end
  end

  assign addr_err = r_addr_err;

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [WIDTH-1:0] r_rda;
      logic [WIDTH-1:0] r_rdb;
      logic             r_rd_valid;

      // The outputs hold their last values while rd_en is low; only rd_valid drops.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rda      <= '0;
          r_rdb      <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          if (rd_en) begin
            r_rda <= w_rda_val;
            r_rdb <= w_rdb_val;
          end
          r_rd_valid <= rd_en;
        end
      end

      assign rda      = r_rda;
      assign rdb      = r_rdb;
      assign rd_valid = r_rd_valid;
    end else begin : g_comb_read
      assign rda      = w_rda_val;
      assign rdb      = w_rdb_val;
      assign rd_valid = rd_en;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  localparam int NC = 5;
  // Configurations: 0 default, 1 no bypass, 2 zero register, 3 depth 6, 4 combinational read.
  localparam int P_D  [NC] = '{8, 8, 8, 6, 8};
  localparam bit P_RR [NC] = '{1, 1, 1, 1, 0};
  localparam bit P_BP [NC] = '{1, 0, 1, 1, 1};
  localparam bit P_Z  [NC] = '{0, 0, 1, 0, 0};

  logic       clk;
  logic       rst, we, rd_en;
  logic [2:0] waddr, ra_sel, rb_sel;
  logic [9:0] wdata;

  logic [NC-1:0][9:0] rda, rdb;
  logic [NC-1:0]      rd_valid, addr_err;

  int tests = 0;
  int fails = 0;

  // Reference state, updated once per clock edge from the behavioural rules.
  logic [9:0] m_mem [NC][8];
  logic [9:0] m_rda [NC];
  logic [9:0] m_rdb [NC];
  logic       m_val [NC];
  logic       m_err [NC];

  regfile_2r1w #(.WIDTH(10), .DEPTH(8), .REG_READ(1), .BYPASS(1), .ZERO_REG(0)) u_c0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rda(rda[0]), .rdb(rdb[0]),
    .rd_valid(rd_valid[0]), .addr_err(addr_err[0]));
  regfile_2r1w #(.WIDTH(10), .DEPTH(8), .REG_READ(1), .BYPASS(0), .ZERO_REG(0)) u_c1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rda(rda[1]), .rdb(rdb[1]),
    .rd_valid(rd_valid[1]), .addr_err(addr_err[1]));
  regfile_2r1w #(.WIDTH(10), .DEPTH(8), .REG_READ(1), .BYPASS(1), .ZERO_REG(1)) u_c2 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rda(rda[2]), .rdb(rdb[2]),
    .rd_valid(rd_valid[2]), .addr_err(addr_err[2]));
  regfile_2r1w #(.WIDTH(10), .DEPTH(6), .REG_READ(1), .BYPASS(1), .ZERO_REG(0)) u_c3 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rda(rda[3]), .rdb(rdb[3]),
    .rd_valid(rd_valid[3]), .addr_err(addr_err[3]));
  regfile_2r1w #(.WIDTH(10), .DEPTH(8), .REG_READ(0), .BYPASS(1), .ZERO_REG(0)) u_c4 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .rda(rda[4]), .rdb(rdb[4]),
    .rd_valid(rd_valid[4]), .addr_err(addr_err[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cfg%0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  // The value a port returns for select s under configuration c, given the current inputs.
  function automatic logic [9:0] m_read(input int c, input logic [2:0] s);
    if (int'(s) >= P_D[c])                return 10'h000;
    if (P_Z[c] && s == 3'd0)              return 10'h000;
    if (P_BP[c] && we && waddr == s)      return wdata;
    return m_mem[c][s];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      logic [9:0] va, vb;
      bit pow2;
      va = m_read(c, ra_sel);
      vb = m_read(c, rb_sel);
      pow2 = (P_D[c] & (P_D[c] - 1)) == 0;
      if (rst) begin
        for (int i = 0; i < 8; i++) m_mem[c][i] = 10'h000;
        m_rda[c] = 10'h000;
        m_rdb[c] = 10'h000;
        m_val[c] = 1'b0;
        m_err[c] = 1'b0;
      end else begin
        if (rd_en) begin
          m_rda[c] = va;
          m_rdb[c] = vb;
        end
        m_val[c] = rd_en;
        if (we && int'(waddr) < P_D[c] && !(P_Z[c] && waddr == 3'd0))
          m_mem[c][waddr] = wdata;
        m_err[c] = !pow2 && ((we && int'(waddr) >= P_D[c]) ||
                             (rd_en && (int'(ra_sel) >= P_D[c] || int'(rb_sel) >= P_D[c])));
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      chk("addr_err", c, 32'(addr_err[c]), 32'(m_err[c]));
      if (P_RR[c]) begin
        chk("rda", c, 32'(rda[c]), 32'(m_rda[c]));
        chk("rdb", c, 32'(rdb[c]), 32'(m_rdb[c]));
        chk("rd_valid", c, 32'(rd_valid[c]), 32'(m_val[c]));
      end else begin
        chk("rda_comb", c, 32'(rda[c]), 32'(m_read(c, ra_sel)));
        chk("rdb_comb", c, 32'(rdb[c]), 32'(m_read(c, rb_sel)));
        chk("rd_valid_comb", c, 32'(rd_valid[c]), 32'(rd_en));
      end
    end
  endtask

  // Drive one cycle of inputs, check before the edge, advance the model, and check after the edge.
  task automatic step(input logic r, input logic w, input logic [2:0] wa, input logic [9:0] wd,
                      input logic re, input logic [2:0] a, input logic [2:0] b);
    rst = r; we = w; waddr = wa; wdata = wd; rd_en = re; ra_sel = a; rb_sel = b;
    #1 check_all();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; rd_en = 1'b0; ra_sel = '0; rb_sel = '0;
    @(posedge clk);
    model_edge();
    #1 check_all();
    chk("reset_rda", 0, 32'(rda[0]), 32'h0);
    chk("reset_valid", 0, 32'(rd_valid[0]), 32'h0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Load i*3+1, then read A=i, B=7-i.
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 10'(i * 3 + 1), 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, 3'(i), 3'(7 - i));
      chk("load_rda", 0, 32'(rda[0]), 32'(i * 3 + 1));
      chk("load_rdb", 0, 32'(rdb[0]), 32'((7 - i) * 3 + 1));
      chk("load_valid", 0, 32'(rd_valid[0]), 32'h1);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("valid_drop", 0, 32'(rd_valid[0]), 32'h0);

    // Same-cycle write and read of register 5.
    step(0, 1, 5, 10'h011, 0, 0, 0);
    step(0, 1, 5, 10'h2AA, 1, 5, 5);
    chk("bypass_on", 0, 32'(rda[0]), 32'h2AA);
    chk("bypass_off", 1, 32'(rda[1]), 32'h011);
    step(0, 0, 0, 0, 1, 5, 5);
    chk("bypass_off_reread", 1, 32'(rda[1]), 32'h2AA);

    // Zero register ignores writes.
    step(0, 1, 0, 10'h3FF, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("zero_rda", 2, 32'(rda[2]), 32'h0);
    chk("zero_rdb", 2, 32'(rdb[2]), 32'h0);
    chk("zero_err", 2, 32'(addr_err[2]), 32'h0);

    // Out-of-range access on the depth-6 file.
    step(0, 1, 6, 10'h155, 1, 7, 0);
    chk("oor_err", 3, 32'(addr_err[3]), 32'h1);
    chk("oor_rda", 3, 32'(rda[3]), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("oor_err_clear", 3, 32'(addr_err[3]), 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 3'(i), 3'(5 - i));

    // Reset in the middle of operation, with a write and a read pending.
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 10'(i * 5 + 2), 0, 0, 0);
    step(1, 1, 2, 10'h0F0, 1, 2, 3);
    chk("rst_valid", 0, 32'(rd_valid[0]), 32'h0);
    chk("rst_rda", 0, 32'(rda[0]), 32'h0);
    chk("rst_rdb", 0, 32'(rdb[0]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, 3'(i), 3'(i));
      chk("rst_cleared", 0, 32'(rda[0]), 32'h0);
    end

    // Combinational read tracks the select within one cycle.
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i), 10'(i + 100), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    rd_en = 1'b1;
    ra_sel = 3'd1; #1 chk("comb_a1", 4, 32'(rda[4]), 32'd101);
    chk("comb_valid", 4, 32'(rd_valid[4]), 32'h1);
    ra_sel = 3'd6; #1 chk("comb_a6", 4, 32'(rda[4]), 32'd106);
    ra_sel = 3'd3; #1 chk("comb_a3", 4, 32'(rda[4]), 32'd103);
    rd_en = 1'b0;  #1 chk("comb_valid_low", 4, 32'(rd_valid[4]), 32'h0);

    // Randomised traffic across all configurations.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom), 10'($urandom),
           ($urandom_range(0, 9) < 7), 3'($urandom), 3'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file with two read ports and one write port. It replaces the fixed eight-register, 10-bit read multiplexer in the datapath. It holds the architectural registers and returns operands A and B to the ALU. It adds a selectable registered-read pipeline stage, write-to-read bypass, an optional hardwired zero register, and out-of-range address detection for non-power-of-two depths.

## Interface
Parameters:
- WIDTH, 10, data width of each register.
- DEPTH, 8, number of registers; must be at least 2.
- REG_READ, 1:
  - 1: read data is registered, so results appear one cycle after rd_en.
  - 0: read data is combinational.
- BYPASS, 1, a same-cycle write to the read address is forwarded to the read output.
- ZERO_REG, 0, when 1 register 0 always reads 0 and writes to it are discarded.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- rd_en  in  1  read request for both ports.
- ra_sel  in  AW  port A register select.
- rb_sel  in  AW  port B register select.
- rda  out  WIDTH  port A data.
- rdb  out  WIDTH  port B data.
- rd_valid  out  1  rda/rdb hold valid data for the accepted request.
- addr_err  out  1  one-cycle pulse: the previous cycle had an out-of-range access.

## Operation
- Storage: DEPTH x WIDTH flops.
- Write: on a clock edge with we=1 and waddr<DEPTH, mem[waddr] <= wdata.
  - With ZERO_REG=1 and waddr=0, the write is dropped silently and raises no error.
- Read value for a port with select s:
  - If s>=DEPTH: 0.
  - Else if ZERO_REG=1 and s=0: 0.
  - Else if BYPASS=1, we=1 and waddr==s (waddr in range): wdata.
  - Else: mem[s].
- Both ports use the same rules independently. ra_sel==rb_sel is legal, and both ports then return identical data.
- REG_READ=1:
  - On an edge with rd_en=1, rda/rdb capture their read values and rd_valid <= 1.
  - On an edge with rd_en=0, rda/rdb hold their previous values and rd_valid <= 0.
- REG_READ=0:
  - rda/rdb are the read values combinationally.
  - rd_valid = rd_en.
  - In this mode the BYPASS forwarding path is combinational from wdata to the outputs.
- addr_err is registered and set on an edge when either of these holds:
  - we=1 and waddr>=DEPTH;
  - rd_en=1 and either select is >=DEPTH.
  - Otherwise it clears on that edge.
  - When DEPTH is a power of two, addr_err is constant 0.
- Reset:
  - rst=1 at an edge clears all of mem, rda, rdb, rd_valid and addr_err to 0.
  - Reset has priority over a simultaneous write or read; the write is lost.
  - Reset in the same cycle as a pending registered read: rd_valid is 0 the next cycle.

## Timing
- Write latency:
  - Data is visible to a non-bypassed read issued in the cycle after the write edge.
  - With BYPASS=1 it is also visible in the write cycle itself.
- Read latency: 1 cycle when REG_READ=1, 0 cycles when REG_READ=0.
- Throughput: one read pair and one write every cycle, with no stalls and no back-pressure.
- With BYPASS=0 and REG_READ=1, a read of the address being written in the same cycle returns the old value.
- Outputs after reset release: rda=rdb=0, rd_valid=0, addr_err=0. The first possible rd_valid=1 is one cycle after the first rd_en.

## Test plan
- Reset, then write mem[i]=i*3+1 for i=0..7 (defaults), then read A=i, B=7-i with rd_en=1 for 8 cycles.
  - Required: rda=i*3+1 and rdb=(7-i)*3+1, with rd_valid=1, each one cycle after the request.
- Same-cycle write and read, waddr=5, wdata=10'h2AA, ra_sel=5, old mem[5]=10'h011.
  - BYPASS=1: rda=10'h2AA next cycle.
  - BYPASS=0: rda=10'h011, and a re-read gives 10'h2AA.
- ZERO_REG=1: write 10'h3FF to register 0, then read A=0 and B=0.
  - Required: rda=rdb=0 and addr_err=0.
- DEPTH=6: write addr 6 with data 10'h155, and read ra_sel=7.
  - Required: the next cycle has addr_err=1 and rda=0.
  - Required: no register changes (all six read back unchanged).
  - Required: addr_err=0 on the following idle cycle.
- Mid-operation reset: after loading registers, assert rst with we=1 (addr 2, data 10'h0F0) and rd_en=1 for one cycle.
  - Required: the next cycle has rd_valid=0 and rda=rdb=0.
  - Required: all registers read 0 afterwards, including addr 2.
- REG_READ=0: change ra_sel combinationally with rd_en=1.
  - Required: rda tracks the select within the same cycle, and rd_valid follows rd_en with no delay.
